// File: rtl/lcd_window_sched.sv
// rtl/lcd_window_sched.sv - ST7789 window scheduler: CASET/RASET/RAMWR then pixel bytes
// Optional LCD_SOLID_FILL_EN adds req_fill/req_color to stream one colour without fetching.
module lcd_window_sched #(
  parameter int         c_x_bits     = 8,
  parameter int         c_y_bits     = 8,
  parameter int         c_color_bits = 16,
  parameter int         c_x_ofs      = 0,
  parameter int         c_y_ofs      = 0,
  parameter logic [7:0] c_caset      = 8'h2A,
  parameter logic [7:0] c_raset      = 8'h2B,
  parameter logic [7:0] c_ramwr      = 8'h2C
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [c_x_bits-1:0]     req_x0,
  input  logic [c_x_bits-1:0]     req_x1,
  input  logic [c_y_bits-1:0]     req_y0,
  input  logic [c_y_bits-1:0]     req_y1,
`ifdef LCD_SOLID_FILL_EN
  input  logic                    req_fill,
  input  logic [c_color_bits-1:0] req_color,
`endif
  output logic [c_x_bits-1:0]     x,
  output logic [c_y_bits-1:0]     y,
  output logic                    pix_req,
  input  logic [c_color_bits-1:0] color,
  output logic [7:0]              byte_data,
  output logic                    byte_dc,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    busy,
  output logic                    done
);

  localparam bit two_bytes = (c_color_bits >= 12);

  typedef enum logic [3:0] {
    S_IDLE, S_CASET_CMD, S_CASET_ARG, S_RASET_CMD, S_RASET_ARG,
    S_RAMWR_CMD, S_FETCH, S_LOAD, S_PIX, S_DONE
  } state_t;

  state_t state, state_next;

  logic [c_x_bits-1:0]     xl, xh, cx, nx;
  logic [c_y_bits-1:0]     yl, yh, cy, ny;
  logic [1:0]              arg_idx;
  logic                    byte_idx;
  logic [c_color_bits-1:0] color_q;
  logic                    fill_q;
  logic                    hs, row_end, last_pix, last_byte;
  logic [15:0]             xs, xe, ys, ye, arg_word, color_ext;
  logic [7:0]              arg_byte;

  assign hs        = byte_valid && byte_ready;
  assign row_end   = (cx == xh);
  assign last_pix  = row_end && (cy == yh);
  assign last_byte = !two_bytes || byte_idx;
  assign nx        = row_end ? xl : cx + c_x_bits'(1);
  assign ny        = row_end ? cy + c_y_bits'(1) : cy;

  // Panel offsets apply only to the address-set arguments, never to x/y.
  assign xs        = 16'(xl) + 16'(c_x_ofs);
  assign xe        = 16'(xh) + 16'(c_x_ofs);
  assign ys        = 16'(yl) + 16'(c_y_ofs);
  assign ye        = 16'(yh) + 16'(c_y_ofs);
  assign arg_word  = (state == S_RASET_ARG) ? (arg_idx[1] ? ye : ys)
                                            : (arg_idx[1] ? xe : xs);
  assign arg_byte  = arg_idx[0] ? arg_word[7:0] : arg_word[15:8];
  assign color_ext = 16'(color_q);

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign pix_req   = (state == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    byte_dc    = 1'b0;
    byte_data  = 8'h00;
    case (state)
      S_IDLE:      if (req_valid) state_next = S_CASET_CMD;
      S_CASET_CMD: begin
        byte_valid = 1'b1;
        byte_data  = c_caset;
        if (hs) state_next = S_CASET_ARG;
      end
      S_CASET_ARG: begin
        byte_valid = 1'b1;
        byte_dc    = 1'b1;
        byte_data  = arg_byte;
        if (hs && arg_idx == 2'd3) state_next = S_RASET_CMD;
      end
      S_RASET_CMD: begin
        byte_valid = 1'b1;
        byte_data  = c_raset;
        if (hs) state_next = S_RASET_ARG;
      end
      S_RASET_ARG: begin
        byte_valid = 1'b1;
        byte_dc    = 1'b1;
        byte_data  = arg_byte;
        if (hs && arg_idx == 2'd3) state_next = S_RAMWR_CMD;
      end
      S_RAMWR_CMD: begin
        byte_valid = 1'b1;
        byte_data  = c_ramwr;
        if (hs) state_next = fill_q ? S_PIX : S_FETCH;
      end
      S_FETCH:     state_next = S_LOAD;
      S_LOAD:      state_next = S_PIX;
      S_PIX: begin
        byte_valid = 1'b1;
        byte_dc    = 1'b1;
        byte_data  = (two_bytes && !byte_idx) ? color_ext[15:8] : color_ext[7:0];
        if (hs && last_byte)
          state_next = last_pix ? S_DONE : (fill_q ? S_PIX : S_FETCH);
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xl <= '0; xh <= '0; yl <= '0; yh <= '0;
      cx <= '0; cy <= '0; x <= '0; y <= '0;
      arg_idx  <= 2'd0;
      byte_idx <= 1'b0;
      color_q  <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        xl <= (req_x0 < req_x1) ? req_x0 : req_x1;
        xh <= (req_x0 < req_x1) ? req_x1 : req_x0;
        yl <= (req_y0 < req_y1) ? req_y0 : req_y1;
        yh <= (req_y0 < req_y1) ? req_y1 : req_y0;
`ifdef LCD_SOLID_FILL_EN
        if (req_fill) color_q <= req_color;
`endif
      end
      if (hs && (state == S_CASET_ARG || state == S_RASET_ARG)) arg_idx <= arg_idx + 2'd1;
      if (hs && state == S_RAMWR_CMD) begin
        cx <= xl;
        cy <= yl;
        byte_idx <= 1'b0;
        if (!fill_q) begin
          x <= xl;
          y <= yl;
        end
      end
      if (state == S_LOAD) color_q <= color;
      // The internal cursor always advances; the visible x/y only when fetching.
      if (hs && state == S_PIX) begin
        byte_idx <= two_bytes ? !byte_idx : 1'b0;
        if (last_byte && !last_pix) begin
          cx <= nx;
          cy <= ny;
          if (!fill_q) begin
            x <= nx;
            y <= ny;
          end
        end
      end
    end
  end

`ifdef LCD_SOLID_FILL_EN
  always_ff @(posedge clk) begin
    if (reset)                          fill_q <= 1'b0;
    else if (state == S_IDLE && req_valid) fill_q <= req_fill;
  end
`else
  assign fill_q = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_window_sched.sv
// tb/tb_lcd_window_sched.sv - randomized scoreboard bench for lcd_window_sched
module tb_lcd_window_sched;
  localparam int XO = 80;
  localparam int YO = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x0, req_x1, req_y0, req_y1;
  logic        req_fill;
  logic [15:0] req_color;
  logic [7:0]  x, y;
  logic        pix_req;
  logic [15:0] color;
  logic [7:0]  byte_data;
  logic        byte_dc, byte_valid, byte_ready, busy, done;

  int          compared = 0;
  int          mismatched = 0;
  logic [8:0]  exp_q[$];
  int          exp_pix;
  int          pix_cnt;
  bit          rnd_ready;
  bit          pend, gap_chk;
  logic [9:0]  pend_word;

  always #5 clk = ~clk;

  lcd_window_sched #(.c_x_ofs(XO), .c_y_ofs(YO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
`ifdef LCD_SOLID_FILL_EN
    .req_fill(req_fill), .req_color(req_color),
`endif
    .x(x), .y(y), .pix_req(pix_req), .color(color),
    .byte_data(byte_data), .byte_dc(byte_dc), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  // Pixel source with one cycle of read latency, colour = y<<8 | x.
  always @(posedge clk) if (pix_req) color <= {y, x};

  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 byte_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push16(input int v);
    exp_q.push_back({1'b1, 8'((v >> 8) & 255)});
    exp_q.push_back({1'b1, 8'(v & 255)});
  endtask

  task automatic push_window(input int x0, x1, y0, y1, input bit fill, input int fcol);
    int xl, xh, yl, yh, c;
    xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
    exp_q.push_back({1'b0, 8'h2A});
    push16((xl + XO) & 16'hFFFF);
    push16((xh + XO) & 16'hFFFF);
    exp_q.push_back({1'b0, 8'h2B});
    push16((yl + YO) & 16'hFFFF);
    push16((yh + YO) & 16'hFFFF);
    exp_q.push_back({1'b0, 8'h2C});
    for (int yy = yl; yy <= yh; yy++)
      for (int xx = xl; xx <= xh; xx++) begin
        c = fill ? fcol : ((yy << 8) | xx);
        push16(c);
      end
    exp_pix = fill ? 0 : (xh - xl + 1) * (yh - yl + 1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      gap_chk = 1'b0;
    end else begin
      if (pend) chk("hold_stable", {byte_valid, byte_dc, byte_data}, pend_word);
      if (pix_req) begin
        pix_cnt++;
        chk("valid_at_pix_req", byte_valid, 0);
        gap_chk = 1'b1;
      end else if (gap_chk) begin
        chk("valid_after_pix_req", byte_valid, 0);
        gap_chk = 1'b0;
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL extra_byte: got %0h expected none", {byte_dc, byte_data});
        end else begin
          chk("byte", {byte_dc, byte_data}, exp_q.pop_front());
        end
      end
      pend = byte_valid && !byte_ready;
      pend_word = {byte_valid, byte_dc, byte_data};
    end
  end

  task automatic issue(input int x0, x1, y0, y1, input bit fill, input int fcol);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("idle_ready", req_ready, 1);
    pix_cnt = 0;
    push_window(x0, x1, y0, y1, fill, fcol);
    req_x0 = 8'(x0); req_x1 = 8'(x1); req_y0 = 8'(y0); req_y1 = 8'(y1);
    req_fill = fill; req_color = 16'(fcol);
    req_valid = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic run_window(input int x0, x1, y0, y1, input bit fill, input int fcol);
    bit got;
    issue(x0, x1, y0, y1, fill, fcol);
    // Requests while busy must be ignored, and latched corners kept.
    req_x0 = 8'($urandom); req_x1 = 8'($urandom); req_fill = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("bytes_left", exp_q.size(), 0);
    chk("pix_req_count", pix_cnt, exp_pix);
    exp_q.delete();
  endtask

  initial begin
    int xa, ya, w, h;
    reset = 1'b1; req_valid = 1'b0; rnd_ready = 1'b0;
    req_x0 = 0; req_x1 = 0; req_y0 = 0; req_y1 = 0; req_fill = 0; req_color = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_req", pix_req, 0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_byte", {byte_dc, byte_data}, 0);
    reset = 1'b0;

    run_window(2, 4, 3, 4, 0, 0);
    rnd_ready = 1'b1;
    run_window(2, 4, 3, 4, 0, 0);
    run_window(4, 2, 4, 3, 0, 0);
    run_window(7, 7, 9, 9, 0, 0);
    run_window(239, 236, 239, 238, 0, 0);
    for (int i = 0; i < 6; i++) begin
      xa = $urandom_range(0, 235); ya = $urandom_range(0, 235);
      w = $urandom_range(0, 4);    h = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) run_window(xa + w, xa, ya, ya + h, 0, 0);
      else                           run_window(xa, xa + w, ya + h, ya, 0, 0);
    end

    issue(0, 239, 0, 239, 0, 0);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 1000 && pix_cnt < 20; cyc++) @(negedge clk);
    chk("big_window_streaming", (pix_cnt >= 20), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("abort_byte_valid", byte_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 1);
    reset = 1'b0;
    run_window(3, 1, 5, 6, 0, 0);

`ifdef LCD_SOLID_FILL_EN
    run_window(0, 0, 0, 0, 1, 16'hF800);
    run_window(10, 12, 20, 21, 1, 16'h1234);
    run_window(5, 6, 5, 5, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", compared);
    $fatal(1);
  end
endmodule
